mmio_timer: RTL

- Memory-mapped 32-bit down-counting timer with prescaler, one-shot/periodic modes and a level interrupt.
- Slave on the CPU native memory bus (valid/ready, wstrb, wdata/rdata), decoded by the top level at 0x0300_0000.
- Sits beside the UART and LED on the I/O bus.
- Returns its own ready and rdata; the top ORs ready and muxes rdata on `sel`.

---
 rtl/mmio_pkg.sv | 29 ++
 rtl/mmio_prescaler.sv | 25 ++
 rtl/mmio_timer.sv | 123 ++++++++++++
 3 files changed

// File: rtl/mmio_pkg.sv
// Shared constants for the memory-mapped I/O blocks: the timer register map, the CTRL bit
// positions and the timer base address decoded at the top level.
package mmio_pkg;

  localparam logic [31:0] TIMER_BASE = 32'h0300_0000;

  localparam logic [2:0] TIMER_CTRL     = 3'd0;
  localparam logic [2:0] TIMER_PRESCALE = 3'd1;
  localparam logic [2:0] TIMER_LOAD     = 3'd2;
  localparam logic [2:0] TIMER_COUNT    = 3'd3;
  localparam logic [2:0] TIMER_STATUS   = 3'd4;

  localparam int unsigned CTRL_EN       = 0;
  localparam int unsigned CTRL_PERIODIC = 1;
  localparam int unsigned CTRL_IRQ_EN   = 2;

  // Merge the bytes of wdata selected by wstrb into old.
  function automatic logic [31:0] apply_wstrb(input logic [31:0] old,
                                               input logic [31:0] wdata,
                                               input logic [3:0]  wstrb);
    logic [31:0] res;
    res = old;
    for (int i = 0; i < 4; i++) begin
      if (wstrb[i]) res[8*i +: 8] = wdata[8*i +: 8];
    end
    return res;
  endfunction

endpackage

// File: rtl/mmio_prescaler.sv
// Prescaler for the timer: pcnt runs 0..limit while enabled and ticks on reaching limit.
module mmio_prescaler #(
  parameter int unsigned PRESCALE_W = 16
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  en,
  input  logic                  clear,
  input  logic [PRESCALE_W-1:0] limit,
  output logic                  tick
);

  logic [PRESCALE_W-1:0] pcnt_q;

  assign tick = en && (pcnt_q == limit);

  always_ff @(posedge clk) begin
    if (reset || clear || !en || tick) begin
      pcnt_q <= '0;
    end else begin
      pcnt_q <= pcnt_q + PRESCALE_W'(1);
    end
  end

endmodule

// File: rtl/mmio_timer.sv
// 32-bit down-counting timer slave on the CPU native memory bus, with prescaler,
// one-shot/periodic modes and a level interrupt.
module mmio_timer
  import mmio_pkg::*;
#(
  parameter int unsigned PRESCALE_W = 16,
  parameter logic [31:0] RESET_LOAD = 32'hFFFF_FFFF
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        sel,
  input  logic        mem_valid,
  input  logic [2:0]  mem_addr,
  input  logic [3:0]  mem_wstrb,
  input  logic [31:0] mem_wdata,
  output logic [31:0] mem_rdata,
  output logic        mem_ready,
  output logic        irq
);

  logic [2:0]            ctrl_q, ctrl_d;
  logic [PRESCALE_W-1:0] prescale_q, prescale_d;
  logic [31:0]           load_q, load_d;
  logic [31:0]           count_q, count_d;
  logic                  match_q, match_d;
  logic                  ready_q;
  logic [31:0]           rdata_q, rd_mux;
  logic                  access, wr, tick, expire, pcnt_clear;

  assign access = sel && mem_valid && !ready_q;
  assign wr     = access && (|mem_wstrb);
  assign expire = tick && (count_q == '0);

  mmio_prescaler #(
    .PRESCALE_W(PRESCALE_W)
  ) u_prescaler (
    .clk  (clk),
    .reset(reset),
    .en   (ctrl_q[CTRL_EN]),
    .clear(pcnt_clear),
    .limit(prescale_q),
    .tick (tick)
  );

  // Order matters: bus writes override the tick decrement, while expiry overrides both
  // a same-cycle MATCH clear and a same-cycle EN write.
  always_comb begin
    ctrl_d     = ctrl_q;
    prescale_d = prescale_q;
    load_d     = load_q;
    count_d    = count_q;
    match_d    = match_q;
    pcnt_clear = 1'b0;

    if (tick) begin
      if (count_q == '0) count_d = ctrl_q[CTRL_PERIODIC] ? load_q : count_q;
      else               count_d = count_q - 32'd1;
    end

    if (wr) begin
      case (mem_addr)
        TIMER_CTRL: begin
          if (mem_wstrb[0]) begin
            ctrl_d     = mem_wdata[2:0];
            pcnt_clear = mem_wdata[CTRL_EN] && !ctrl_q[CTRL_EN];
          end
        end
        TIMER_PRESCALE: prescale_d = PRESCALE_W'(apply_wstrb(32'(prescale_q), mem_wdata,
                                                             mem_wstrb));
        TIMER_LOAD:     load_d     = apply_wstrb(load_q, mem_wdata, mem_wstrb);
        TIMER_COUNT: begin
          count_d    = apply_wstrb(count_q, mem_wdata, mem_wstrb);
          pcnt_clear = 1'b1;
        end
        TIMER_STATUS: begin
          if (mem_wstrb[0] && mem_wdata[0]) match_d = 1'b0;
        end
        default: ;
      endcase
    end

    if (expire) begin
      match_d = 1'b1;
      if (!ctrl_q[CTRL_PERIODIC]) ctrl_d[CTRL_EN] = 1'b0;
    end
  end

  always_comb begin
    case (mem_addr)
      TIMER_CTRL:     rd_mux = {29'd0, ctrl_q};
      TIMER_PRESCALE: rd_mux = 32'(prescale_q);
      TIMER_LOAD:     rd_mux = load_q;
      TIMER_COUNT:    rd_mux = count_q;
      TIMER_STATUS:   rd_mux = {31'd0, match_q};
      default:        rd_mux = 32'd0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      ctrl_q     <= '0;
      prescale_q <= '0;
      load_q     <= RESET_LOAD;
      count_q    <= '0;
      match_q    <= 1'b0;
      ready_q    <= 1'b0;
      rdata_q    <= '0;
    end else begin
      ctrl_q     <= ctrl_d;
      prescale_q <= prescale_d;
      load_q     <= load_d;
      count_q    <= count_d;
      match_q    <= match_d;
      ready_q    <= access;
      if (access) rdata_q <= rd_mux;
    end
  end

  assign mem_ready = ready_q;
  assign mem_rdata = rdata_q;
  assign irq       = match_q && ctrl_q[CTRL_IRQ_EN];

endmodule
